// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, legal prescale
// ratios and parity-type codes.
package uart_rx_pkg;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } rx_state_t;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the receiver: edge counter, three-point majority
// vote around mid-bit, and the vote/end-of-bit strobes.
module uart_rx_sampler #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  rx_s,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  vote,
    output logic                  vote_strobe,
    output logic                  bit_end
);

    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last_cnt;
    logic                  smp_a;
    logic                  smp_b;

    assign half     = prescale >> 1;
    assign last_cnt = prescale - ONE;

    // >= rather than == so a prescale shrunk mid-frame still wraps.
    assign bit_end     = run && (edge_cnt >= last_cnt);
    // Third sample is the live rx_s, so the vote lands in the flops as
    // edge_cnt steps onto prescale/2+2.
    assign vote_strobe = run && (edge_cnt == half + ONE);
    assign vote        = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
        end else begin
            if (!run || bit_end) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + ONE;
            end
            if (edge_cnt == half - ONE) begin
                smp_a <= rx_s;
            end
            if (edge_cnt == half) begin
                smp_b <= rx_s;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: input synchronizer, framing FSM, shift register,
// parity check and registered result pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  parity_EN,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int                BCW      = $clog2(DATA_WIDTH) + 1;
    localparam logic [BCW-1:0]    LAST_BIT = BCW'(DATA_WIDTH - 1);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [1:0]            sync;
    logic                  rx_s;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err;
    logic                  vote;
    logic                  vote_strobe;
    logic                  bit_end;
    logic                  dv_nxt;
    logic                  pe_nxt;
    logic                  se_nxt;
    logic                  par_exp;

    assign rx_s    = sync[1];
    assign busy    = (state != IDLE);
    assign par_exp = (^shreg) ^ (parity_type == PARITY_ODD);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (CLK),
        .rst_n       (RST),
        .run         (busy),
        .rx_s        (rx_s),
        .prescale    (prescale),
        .vote        (vote),
        .vote_strobe (vote_strobe),
        .bit_end     (bit_end)
    );

    always_comb begin
        state_nxt = state;
        dv_nxt    = 1'b0;
        pe_nxt    = 1'b0;
        se_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (vote_strobe && vote) state_nxt = IDLE;
                else if (bit_end)        state_nxt = DATA;
            end
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
                    state_nxt = parity_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) state_nxt = STOP;
            end
            STOP: begin
                // Leave mid-stop-bit so a back-to-back start edge is caught;
                // bit_end exit only matters for illegal tiny prescales.
                if (vote_strobe) begin
                    state_nxt = IDLE;
                    if (!vote)        se_nxt = 1'b1;
                    else if (par_err) pe_nxt = 1'b1;
                    else              dv_nxt = 1'b1;
                end else if (bit_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync         <= 2'b11;
            state        <= IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_err      <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            sync         <= {sync[0], RX_IN};
            state        <= state_nxt;
            data_valid   <= dv_nxt;
            parity_error <= pe_nxt;
            stop_error   <= se_nxt;
            if (dv_nxt) begin
                P_DATA <= shreg;
            end
            if (state == IDLE) begin
                bit_cnt <= '0;
                par_err <= 1'b0;
            end
            if ((state == DATA) && vote_strobe) begin
                shreg <= {vote, shreg[DATA_WIDTH-1:1]};
            end
            if ((state == DATA) && bit_end) begin
                bit_cnt <= bit_cnt + BCW'(1);
            end
            if ((state == PARITY) && vote_strobe) begin
                par_err <= (vote != par_exp);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written corner sequences.
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] prescale = 6'd8;
    logic       parity_EN = 1'b0;
    logic       parity_type = 1'b0;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    uart_rx dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .prescale     (prescale),
        .parity_EN    (parity_EN),
        .parity_type  (parity_type),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int passed = 0;

    int dv_cnt = 0;
    int pe_cnt = 0;
    int se_cnt = 0;
    int wide_cnt = 0;
    logic dv_d = 1'b0;
    logic [7:0] rx_q[$];

    always @(negedge CLK) begin
        if (data_valid) begin
            dv_cnt++;
            rx_q.push_back(P_DATA);
        end
        if (parity_error) pe_cnt++;
        if (stop_error) se_cnt++;
        if (data_valid && dv_d) wide_cnt++;
        dv_d = data_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic drive_bit(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input int ps, input logic pen, input logic pbit,
                              input logic [7:0] d, input logic stop);
        drive_bit(1'b0, ps);
        for (int b = 0; b < 8; b++) drive_bit(d[b], ps);
        if (pen) drive_bit(pbit, ps);
        drive_bit(stop, ps);
        drive_bit(1'b1, 2 * ps + 4);
    endtask

    task automatic tx_byte(input int ps, input logic ptype, input logic [7:0] d);
        drive_bit(1'b0, ps);
        for (int b = 0; b < 8; b++) drive_bit(d[b], ps);
        drive_bit((^d) ^ ptype, ps);
        drive_bit(1'b1, ps);
    endtask

    typedef struct {
        logic [5:0] ps;
        logic       pen;
        logic       ptype;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        int         kind;       // 0 data_valid, 1 parity_error, 2 stop_error
        logic [7:0] exp_pdata;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int dv0, pe0, se0, lat, bcnt;
        logic [7:0] d;

        vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 8'hA5};
        vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 0, 8'h07};
        vecs[2] = '{6'd16, 1'b1, 1'b0, 8'h07, 1'b0, 1'b1, 1, 8'h07};
        vecs[3] = '{6'd32, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 2, 8'h07};
        vecs[4] = '{6'd8,  1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 0, 8'h3C};
        vecs[5] = '{6'd32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 0, 8'h81};
        vecs[6] = '{6'd16, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1, 8'h81};

        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", {busy, data_valid, parity_error, stop_error}, 0);
        check("reset_pdata", P_DATA, 0);
        RST = 1'b1;
        drive_bit(1'b1, 8);

        for (int i = 0; i < 7; i++) begin
            prescale    = vecs[i].ps;
            parity_EN   = vecs[i].pen;
            parity_type = vecs[i].ptype;
            drive_bit(1'b1, 4);
            dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
            send_frame(int'(vecs[i].ps), vecs[i].pen, vecs[i].pbit, vecs[i].data, vecs[i].stop);
            check($sformatf("v%0d_data_valid", i), dv_cnt - dv0, int'(vecs[i].kind == 0));
            check($sformatf("v%0d_parity_error", i), pe_cnt - pe0, int'(vecs[i].kind == 1));
            check($sformatf("v%0d_stop_error", i), se_cnt - se0, int'(vecs[i].kind == 2));
            check($sformatf("v%0d_pdata", i), P_DATA, vecs[i].exp_pdata);
            check($sformatf("v%0d_idle", i), busy, 0);
        end

        // Latency: data_valid P/2+5 cycles after the stop bit reaches RX_IN.
        prescale = 6'd8; parity_EN = 1'b0;
        drive_bit(1'b1, 4);
        d = 8'h96;
        drive_bit(1'b0, 8);
        for (int b = 0; b < 8; b++) drive_bit(d[b], 8);
        RX_IN = 1'b1;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (data_valid) begin
                lat = n;
                break;
            end
        end
        check("latency_p8", lat, 9);
        check("latency_pdata", P_DATA, 8'h96);
        @(negedge CLK);
        check("busy_after_valid", busy, 0);
        check("valid_one_cycle", data_valid, 0);
        @(posedge CLK);
        #1;
        drive_bit(1'b1, 20);

        // Two-sample glitch must not survive START.
        prescale = 6'd16;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        RX_IN = 1'b0;
        bcnt = 0;
        for (int n = 0; n < 60; n++) begin
            if (n == 2) RX_IN = 1'b1;
            @(negedge CLK);
            if (busy) bcnt++;
        end
        @(posedge CLK);
        #1;
        check("glitch_busy_short", int'(bcnt > 0 && bcnt < 16), 1);
        check("glitch_no_pulses", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("glitch_idle", busy, 0);

        // One corrupted sample in bits 1 and 6 is outvoted.
        d = 8'h5A;
        dv0 = dv_cnt;
        drive_bit(1'b0, 16);
        for (int b = 0; b < 8; b++) begin
            if (b == 1 || b == 6) begin
                drive_bit(d[b], 8);
                drive_bit(~d[b], 1);
                drive_bit(d[b], 7);
            end else begin
                drive_bit(d[b], 16);
            end
        end
        drive_bit(1'b1, 40);
        check("majority_valid", dv_cnt - dv0, 1);
        check("majority_pdata", P_DATA, 8'h5A);

        // Asynchronous reset in the middle of DATA.
        prescale = 6'd8;
        drive_bit(1'b0, 8);
        drive_bit(1'b1, 8);
        drive_bit(1'b0, 8);
        #2;
        RST = 1'b0;
        #1;
        check("midreset_outputs", {busy, data_valid, parity_error, stop_error}, 0);
        check("midreset_pdata", P_DATA, 0);
        RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        drive_bit(1'b1, 8);
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        send_frame(8, 1'b0, 1'b0, 8'h3C, 1'b1);
        check("post_reset_valid", dv_cnt - dv0, 1);
        check("post_reset_errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("post_reset_pdata", P_DATA, 8'h3C);

        // Held-low break: repeated stop errors, then recovery to idle.
        pe0 = pe_cnt; se0 = se_cnt;
        drive_bit(1'b0, 300);
        drive_bit(1'b1, 200);
        check("break_stop_errors", int'((se_cnt - se0) >= 2), 1);
        check("break_no_parity", pe_cnt - pe0, 0);
        check("break_recovers", busy, 0);

        // Back-to-back frames from a transmitter model, even parity.
        parity_EN = 1'b1; parity_type = 1'b0;
        drive_bit(1'b1, 8);
        rx_q.delete();
        pe0 = pe_cnt; se0 = se_cnt;
        tx_byte(8, 1'b0, 8'h00);
        tx_byte(8, 1'b0, 8'h55);
        tx_byte(8, 1'b0, 8'hC3);
        drive_bit(1'b1, 30);
        check("loop_count", rx_q.size(), 3);
        check("loop_byte0", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 8'h00);
        check("loop_byte1", (rx_q.size() > 1) ? int'(rx_q[1]) : -1, 8'h55);
        check("loop_byte2", (rx_q.size() > 2) ? int'(rx_q[2]) : -1, 8'hC3);
        check("loop_errors", (pe_cnt - pe0) + (se_cnt - se0), 0);
        check("valid_width", wide_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; counterpart of the team's UART transmitter.
- Oversamples RX_IN at a programmable prescale and majority-votes three mid-bit samples.
- Deframes start / 8 data (LSB first) / optional parity / stop, and presents the byte on P_DATA with a one-cycle data_valid pulse.
- Sits between the pad-side serial line and the parallel consumer (register file / FIFO).

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of prescale input. Legal prescale values are 8, 16 and 32.

Ports:
- CLK  input  1  oversampling clock (prescale × bit rate).
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idle high.
- prescale  input  PRESCALE_W  oversampling ratio; static while not idle.
- parity_EN  input  1  1 = frame carries a parity bit.
- parity_type  input  1  0 = even (bit = ^data), 1 = odd (bit = ~^data).
- P_DATA  output  DATA_WIDTH  last received byte.
- data_valid  output  1  one-cycle pulse: P_DATA is new and error-free.
- parity_error  output  1  one-cycle pulse on parity mismatch.
- stop_error  output  1  one-cycle pulse when the stop bit is sampled 0.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (async, RST=0): state IDLE; P_DATA=0; data_valid, parity_error, stop_error and busy all 0; counters 0; synchronizer flops 1.
- Input path: RX_IN passes through a 2-flop synchronizer; rx_s denotes the synchronized value. All timing below is relative to rx_s.
- edge_cnt: counts 0..prescale-1 within each bit period, then wraps to 0 and increments bit_cnt.
- Sampling: the bit value is the majority of rx_s at edge_cnt = prescale/2-1, prescale/2 and prescale/2+1. The vote is registered when edge_cnt = prescale/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on rx_s=0, go to START with edge_cnt=0 and busy=1.
- START: at the vote point, if the sample is 1 (glitch), return to IDLE with no flags. At edge_cnt=prescale-1, go to DATA.
- DATA: each voted bit shifts in LSB first. After bit_cnt reaches DATA_WIDTH-1 and edge_cnt=prescale-1, go to PARITY if parity_EN=1, otherwise STOP.
- PARITY: compare the voted bit with the expected parity of the shift register. Latch a mismatch internally. At end of bit, go to STOP.
- STOP: at the vote point, decide in the same cycle:
  - Voted bit = 0: pulse stop_error.
  - Otherwise, parity mismatch latched: pulse parity_error.
  - Otherwise: load P_DATA from the shift register and pulse data_valid.
  - Exactly one of the three pulses fires per frame.
  - Then go to IDLE immediately; busy=0 the next cycle. Returning mid-stop-bit is intentional, so back-to-back frames are caught.
- Latency: data_valid asserts (prescale/2+3) CLK after the stop-bit leading edge on rx_s, plus 2 synchronizer cycles from RX_IN.
- P_DATA is held until the next good frame; it is not updated on error frames.
- parity_EN, parity_type and prescale are sampled continuously but must be stable while busy. Changes while busy give undefined frame results, but the FSM must still return to IDLE.
- After a stop error, if rx_s stays 0 (break), IDLE sees 0 and starts a new frame. This is accepted: the break yields repeated stop_error pulses, never a hang.
- Illegal prescale (below 8): behaviour undefined. The counters must still wrap and not lock up.

Decomposition:
- Shared package uart_rx_pkg:
  - State enum localparams (one-hot, 5 bits, matching the TX FSM encoding style).
  - PRESCALE_8/16/32 constants.
  - Parity-type constants EVEN=0, ODD=1.
- Sub-module uart_rx_sampler: contains edge_cnt, the 3-sample majority vote and the vote_strobe/bit_end strobes.
- The top contains the synchronizer, FSM, shift register, parity check and output flops.

Test Plan:
- Reset mid-frame (RST low during DATA) -> all outputs 0 immediately; the next clean frame 0x3C is received correctly.
- prescale=8, parity_EN=0, send 0xA5 -> P_DATA=0xA5, data_valid one cycle, no error pulses; busy low one cycle later.
- prescale=16, parity_EN=1, parity_type=0, send 0x07 with parity bit 1 -> data_valid, P_DATA=0x07. Resend with parity bit 0 -> parity_error pulse, P_DATA stays 0x07.
- prescale=32, odd parity, send 0xFF with stop bit 0 -> stop_error only; P_DATA unchanged; FSM back to IDLE.
- 2-sample-wide low glitch on RX_IN (prescale=16) -> no busy beyond START, no pulses. Then one sample corrupted mid-bit in frame 0x5A -> majority vote yields 0x5A.
- Loopback with the team's UART transmitter at prescale=8, three back-to-back bytes 0x00/0x55/0xC3 with parity on -> three data_valid pulses with matching P_DATA, in order.
